// File: rtl/dmem_master_if.sv
// Bus bundle for dmem_master: pipeline request/response channel plus the
// registered-address data-memory port.
interface dmem_master_if;
    // Pipeline request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Pipeline response channel
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_led;

    // Data-memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;

    // Initiator side (the dmem_master itself)
    modport master (
        input  req_valid,
        input  req_write,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  mem_read_data,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output resp_led,
        output mem_addr,
        output mem_write_data,
        output mem_memwrite,
        output mem_memread,
        output mem_sign_mask
    );

    // Environment side (pipeline and memory)
    modport slave (
        output req_valid,
        output req_write,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output mem_read_data,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  resp_led,
        input  mem_addr,
        input  mem_write_data,
        input  mem_memwrite,
        input  mem_memread,
        input  mem_sign_mask
    );
endinterface

// File: rtl/dmem_master.sv
// Load/store initiator for the data memory. Takes one request at a time,
// presents the address a cycle ahead of the strobe, captures read data the
// cycle after the strobe and answers with a single-cycle response pulse.
module dmem_master #(
    parameter bit          CHECK_ALIGN = 1'b1,
    parameter logic [31:0] LED_ADDR    = 32'h0000_2000
) (
    input logic           clk,
    input logic           rst_n,
    dmem_master_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StCapture,
        StErr
    } state_e;

    state_e      state_q;

    // Holding registers for the accepted request
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [3:0]  mask_q;
    logic        led_q;

    // Registered outputs
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        resp_led_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_write_data_q;
    logic        mem_memwrite_q;
    logic        mem_memread_q;
    logic [3:0]  mem_sign_mask_q;

    // Request decode
    logic [3:0]  dec_mask;
    logic        dec_illegal;
    logic        dec_misaligned;
    logic        dec_reject;
    logic        accept;

    // Decode funct3 into the memory sign_mask and classify illegal/misaligned requests.
    always_comb begin
        dec_mask       = 4'b0000;
        dec_illegal    = 1'b0;
        dec_misaligned = 1'b0;
        unique case (bus.req_funct3)
            3'b000:  dec_mask = 4'b1001;  // LB / SB
            3'b001:  dec_mask = 4'b1011;  // LH / SH
            3'b010:  dec_mask = 4'b0111;  // LW / SW
            3'b100:  dec_mask = 4'b0001;  // LBU
            3'b101:  dec_mask = 4'b0011;  // LHU
            default: dec_illegal = 1'b1;
        endcase
        // Stores never sign-extend, and have no unsigned variants.
        if (bus.req_write) begin
            dec_mask[3] = 1'b0;
            if (bus.req_funct3[2]) begin
                dec_illegal = 1'b1;
            end
        end
        unique case (bus.req_funct3)
            3'b001, 3'b101: dec_misaligned = bus.req_addr[0];
            3'b010:         dec_misaligned = (bus.req_addr[1:0] != 2'b00);
            default:        dec_misaligned = 1'b0;
        endcase
        dec_reject = dec_illegal | (CHECK_ALIGN & dec_misaligned);
    end

    assign accept = (state_q == StIdle) & req_ready_q & bus.req_valid;

    // Transaction FSM; every bus-facing output is a register set here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            addr_q           <= 32'h0;
            wdata_q          <= 32'h0;
            write_q          <= 1'b0;
            mask_q           <= 4'b0000;
            led_q            <= 1'b0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'h0;
            resp_err_q       <= 1'b0;
            resp_led_q       <= 1'b0;
            mem_addr_q       <= 32'h0;
            mem_write_data_q <= 32'h0;
            mem_memwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            mem_sign_mask_q  <= 4'b0000;
        end else begin
            // Pulses and strobe-cycle signals default low; the state arms override.
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_led_q       <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            mem_sign_mask_q  <= 4'b0000;
            mem_write_data_q <= 32'h0;

            // Ready comes back only once the response cycle has been seen.
            if (resp_valid_q) begin
                req_ready_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        write_q     <= bus.req_write;
                        mask_q      <= dec_mask;
                        led_q       <= (bus.req_addr == LED_ADDR);
                        req_ready_q <= 1'b0;
                        if (dec_reject) begin
                            state_q <= StErr;
                        end else begin
                            // Address goes out one cycle ahead of the strobe.
                            mem_addr_q <= bus.req_addr;
                            state_q    <= StSetup;
                        end
                    end
                end

                StSetup: begin
                    mem_memwrite_q   <= write_q;
                    mem_memread_q    <= ~write_q;
                    mem_sign_mask_q  <= mask_q;
                    mem_write_data_q <= wdata_q;
                    state_q          <= StStrobe;
                end

                StStrobe: begin
                    if (write_q) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 32'h0;
                        resp_led_q   <= led_q;
                        state_q      <= StIdle;
                    end else begin
                        state_q <= StCapture;
                    end
                end

                StCapture: begin
                    // Memory read data is valid the cycle after the strobe.
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= bus.mem_read_data;
                    resp_led_q   <= led_q;
                    state_q      <= StIdle;
                end

                StErr: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= 32'h0;
                    resp_led_q   <= led_q;
                    state_q      <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.resp_led       = resp_led_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_memwrite   = mem_memwrite_q;
    assign bus.mem_memread    = mem_memread_q;
    assign bus.mem_sign_mask  = mem_sign_mask_q;

endmodule

// File: tb/tb_dmem_master.sv
// Scoreboard bench for dmem_master: each request pushes its expected
// strobe/response profile, a negedge monitor checks strobes and pops on resp_valid.
module tb_dmem_master;

    localparam logic [31:0] LedAddr = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dmem_master_if bus ();

    dmem_master #(
        .CHECK_ALIGN (1'b1),
        .LED_ADDR    (LedAddr)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        led;
        int          lat;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nrd;
        int          nwr;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_resp   = 0;
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    logic [31:0] rd_val   = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] prev_addr = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Cycle counter and registered-read memory model
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_memread) mem_rdata <= rd_val;
        else                 mem_rdata <= 32'h5555_aaaa;
    end
    assign bus.mem_read_data = mem_rdata;

    // Monitor: strobe checks against the head entry, pop on response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.mem_memread || bus.mem_memwrite) begin
                    check("strobe_excl", {31'd0, bus.mem_memread & bus.mem_memwrite}, 32'd0);
                    if (sb.size() == 0) begin
                        check("strobe_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("strobe_mask", {28'd0, bus.mem_sign_mask}, {28'd0, sb[0].mask});
                        check("strobe_addr", bus.mem_addr, sb[0].addr);
                        check("setup_addr", prev_addr, sb[0].addr);
                        if (bus.mem_memwrite) check("strobe_wdata", bus.mem_write_data, sb[0].wdata);
                    end
                    if (bus.mem_memread)  rd_cnt++;
                    if (bus.mem_memwrite) wr_cnt++;
                end
                if (bus.resp_valid) begin
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_rdata", bus.resp_rdata, e.rdata);
                        check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                        check("resp_led", {31'd0, bus.resp_led}, {31'd0, e.led});
                        check("resp_latency", cyc - e.acc_cyc, e.lat);
                        check("memread_count", rd_cnt, e.nrd);
                        check("memwrite_count", wr_cnt, e.nwr);
                        check("ready_at_resp", {31'd0, bus.req_ready}, 32'd0);
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                    n_resp++;
                end
                prev_addr = bus.mem_addr;
            end
        end
    end

    // Issue one request at the next negedge and wait for its response.
    // req_valid stays high with junk while busy to show busy-time requests are ignored.
    task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rv, input logic err,
                        input logic [3:0] mask, input int lat);
        exp_t e;
        int   start;
        int   waited;
        @(negedge clk);
        #1;
        check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
        rd_val         = rv;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        e.rdata   = (err || wr) ? 32'h0 : rv;
        e.err     = err;
        e.led     = (addr == LedAddr);
        e.lat     = lat;
        e.mask    = mask;
        e.addr    = addr;
        e.wdata   = wd;
        e.nrd     = (!err && !wr) ? 1 : 0;
        e.nwr     = (!err && wr) ? 1 : 0;
        e.acc_cyc = cyc;
        sb.push_back(e);
        start = n_resp;
        @(negedge clk);
        #1;
        bus.req_write  = $urandom_range(0, 1) != 0;
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
        waited = 0;
        while (n_resp == start && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        bus.req_valid = 1'b0;
        if (n_resp == start) begin
            check("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        int start;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        rst_n          = 1'b0;
        #1;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_write_data, 32'h0);
        check("rst_mask", {28'd0, bus.mem_sign_mask}, 32'd0);
        check("rst_strobes", {30'd0, bus.mem_memread, bus.mem_memwrite}, 32'd0);
        #1;
        rst_n = 1'b1;

        //   wr    f3      addr          wdata         mem data      err   mask     lat
        send(1'b0, 3'b010, 32'h0000_1004, 32'h0,        32'hdead_beef, 1'b0, 4'b0111, 4); // LW
        send(1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'hffff_ff80, 1'b0, 4'b1001, 4); // LB
        send(1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h0000_0080, 1'b0, 4'b0001, 4); // LBU
        send(1'b1, 3'b001, 32'h0000_1002, 32'h0000_abcd, 32'h0,       1'b0, 4'b0011, 3); // SH
        send(1'b1, 3'b010, 32'h0000_1001, 32'h1234_5678, 32'h0,       1'b1, 4'b0000, 2); // SW misaligned
        send(1'b1, 3'b010, LedAddr,       32'h0000_00a5, 32'h0,       1'b0, 4'b0111, 3); // SW LED
        send(1'b0, 3'b010, LedAddr,       32'h0,        32'h0000_0001, 1'b0, 4'b0111, 4); // LW LED, back-to-back
        send(1'b0, 3'b101, 32'h0000_1001, 32'h0,        32'h0,        1'b1, 4'b0000, 2); // LHU misaligned
        send(1'b0, 3'b011, 32'h0000_1000, 32'h0,        32'h0,        1'b1, 4'b0000, 2); // illegal funct3
        send(1'b1, 3'b100, 32'h0000_1000, 32'h0000_0011, 32'h0,       1'b1, 4'b0000, 2); // store with f3[2]
        send(1'b1, 3'b000, 32'h0000_1007, 32'h0000_00ee, 32'h0,       1'b0, 4'b0001, 3); // SB
        send(1'b0, 3'b001, 32'h0000_1006, 32'h0,        32'hffff_8001, 1'b0, 4'b1011, 4); // LH

        // Reset in the middle of a load strobe
        @(negedge clk);
        #1;
        rd_val         = 32'hcafe_f00d;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_1008;
        sb.push_back('{rdata: 32'hcafe_f00d, err: 1'b0, led: 1'b0, lat: 4, mask: 4'b0111,
                       addr: 32'h0000_1008, wdata: 32'h0, nrd: 1, nwr: 0, acc_cyc: cyc});
        @(negedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("abort_in_strobe", {31'd0, bus.mem_memread}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_memread", {31'd0, bus.mem_memread}, 32'd0);
        check("abort_memwrite", {31'd0, bus.mem_memwrite}, 32'd0);
        check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        sb.delete();
        rd_cnt = 0;
        wr_cnt = 0;
        start  = n_resp;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("no_resp_after_reset", n_resp - start, 32'd0);

        // Recovery after the aborted transaction
        send(1'b0, 3'b010, 32'h0000_100c, 32'h0, 32'h0bad_c0de, 1'b0, 4'b0111, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_master.md
Name: dmem_master

Overview:
- Load/store initiator that drives the data-memory port on behalf of the core pipeline.
- Accepts one load or store request per transaction through a valid/ready handshake.
- Sequences the memory's registered-address protocol: the address is presented one cycle ahead of the strobe, and read data returns one cycle after the strobe.
- Encodes access size and signedness into sign_mask, rejects misaligned accesses, and returns load data to the pipeline with a response pulse.

Parameters:
CHECK_ALIGN, 1, 1 = misaligned half/word requests rejected with resp_err; 0 = forwarded unchanged
LED_ADDR, 32'h0000_2000, LED register address; requests to it are forwarded normally and also flagged on resp_led

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  pipeline request valid
req_ready  output  1  master idle and able to accept a request
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, valid with resp_valid
resp_err  output  1  misaligned or illegal funct3, valid with resp_valid
resp_led  output  1  address equalled LED_ADDR, valid with resp_valid
mem_addr  output  32  to memory addr
mem_write_data  output  32  to memory write_data
mem_memwrite  output  1  to memory memwrite
mem_memread  output  1  to memory memread
mem_sign_mask  output  4  to memory sign_mask
mem_read_data  input  32  from memory read_data

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid, resp_err, resp_led, mem_memwrite, mem_memread = 0; resp_rdata, mem_addr, mem_write_data = 0; mem_sign_mask = 4'b0000.
- Reset mid-transaction: strobes drop immediately, any in-flight response is discarded, and no resp_valid is issued after release.
- sign_mask encoding:
  - byte = 0001, half = 0011, word = 0111.
  - Bit 3 = sign-extend; it is set only for loads B and H.
  - BU = 0001, HU = 0011.
  - Stores always have bit 3 = 0.
- Request capture: accept when req_valid & req_ready, which is possible only in IDLE. On accept, latch addr, wdata, write, and mask into holding registers. Request inputs are ignored while not IDLE.
- FSM states: IDLE, SETUP, STROBE, CAPTURE, ERR.
  - IDLE -> SETUP on accept of a legal, aligned request.
  - IDLE -> ERR on accept of a misaligned request (CHECK_ALIGN=1) or illegal funct3 (011, 110, 111; and any funct3[2]=1 on a store).
    - Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - SETUP (1 cycle): mem_addr = latched addr; strobes 0. -> STROBE.
  - STROBE (1 cycle):
    - mem_addr is held.
    - mem_sign_mask and mem_write_data are driven.
    - Store: mem_memwrite=1 and mem_memread=0. Next state is IDLE, and resp_valid pulses in the following cycle with resp_rdata=0.
    - Load: mem_memread=1. Next state is CAPTURE.
  - CAPTURE (1 cycle): strobes 0. resp_rdata <= mem_read_data; resp_valid=1 in the next cycle; -> IDLE.
  - ERR (1 cycle): no memory strobe is ever asserted. resp_valid=1, resp_err=1, resp_rdata=0 in the next cycle; -> IDLE.
- Latencies, measured from the accept edge:
  - Store: resp_valid after 3 cycles, with exactly one memwrite cycle.
  - Load: resp_valid after 4 cycles.
  - Error: resp_valid after 2 cycles.
- req_ready is 0 from the cycle after accept until the cycle resp_valid is asserted, inclusive of that cycle. It returns to 1 the cycle after resp_valid.
- Store data is forwarded unshifted (right-aligned); the memory performs byte/half lane merge.
- Load data is taken unmodified from mem_read_data; the memory performs extension.
- mem_memread and mem_memwrite are never both 1. Each is high for at most one cycle per transaction.
- resp_led = (latched addr == LED_ADDR). LED writes still use the normal store sequence.
- resp_valid, resp_err, and resp_led are single-cycle pulses. resp_rdata holds its value until the next response.

Test Plan:
- Reset: assert rst_n=0 mid-STROBE of a load -> strobes 0 immediately; req_ready=1; no resp_valid after release.
- LW at 0x0000_1004, memory returns 0xDEAD_BEEF:
  - mem_addr=0x1004 in SETUP and STROBE.
  - Single memread with mask 0111.
  - resp_valid 4 cycles after accept with resp_rdata=0xDEAD_BEEF, resp_err=0.
- LB at 0x1003 then LBU at 0x1003 -> masks 1001 then 0001; both complete; req_ready low during each transaction.
- SH of 0x0000_ABCD at 0x1002 -> one memwrite cycle, mask 0011, write_data=0x0000_ABCD; resp_valid 3 cycles after accept.
- SW at 0x1001 (CHECK_ALIGN=1) -> no memread/memwrite ever; resp_valid 2 cycles after accept with resp_err=1, resp_rdata=0.
- SW 0x0000_00A5 to 0x2000 -> normal store sequence, resp_led=1; a following request is accepted in the cycle after resp_valid.
